// File: rtl/axi_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_sram_slave
//
// AXI4-Lite slave backed by an internal word array. It terminates the master
// port of the memory-to-AXI bridge and is the default RAM target in
// simulation and FPGA builds. Writes and reads are single-beat. The write
// channel and the read channel are fully independent of each other.
//
// Handshake rule (all five channels): a transfer happens on a rising clk edge
// where both valid and ready are sampled high. A source that raises valid
// holds it, and its payload stable, until that edge. Every ready/valid driven
// by this block comes straight from a flop, so no input valid or ready
// reaches an output combinationally.
//
// Ports:
//   clk, rst              clock (posedge) and asynchronous active-high reset
//   awaddr/awport/awvalid/awready   write address channel (awport ignored)
//   wdata/wstrb/wvalid/wready       write data channel
//   bresp/bvalid/bready             write response channel
//   araddr/arport/arvalid/arready   read address channel (arport ignored)
//   rdata/rresp/rvalid/rready       read data channel
//
// Responses: OKAY (00) for an aligned in-range address, SLVERR (10) for an
// in-range address that is not 8-byte aligned, and DECERR (11) for an address
// outside [BASE_ADDR, BASE_ADDR + MEM_DEPTH*8). DECERR wins over SLVERR.
// Only OKAY writes modify the array. Error reads return zero data.
//
// C_S_AXI_DATA_WIDTH must be 64 (8 byte lanes per word).
// ---------------------------------------------------------------------------
module axi_lite_sram_slave #(
    parameter int          C_S_AXI_ADDR_WIDTH = 64,
    parameter int          C_S_AXI_DATA_WIDTH = 64,
    parameter int          MEM_DEPTH          = 4096,
    parameter logic [63:0] BASE_ADDR          = 64'h0
) (
    input  logic                              clk,
    input  logic                              rst,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr,
    input  logic [2:0]                        awport,
    input  logic                              awvalid,
    output logic                              awready,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb,
    input  logic                              wvalid,
    output logic                              wready,
    // write response channel
    output logic [1:0]                        bresp,
    output logic                              bvalid,
    input  logic                              bready,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr,
    input  logic [2:0]                        arport,
    input  logic                              arvalid,
    output logic                              arready,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                        rresp,
    output logic                              rvalid,
    input  logic                              rready
);

    localparam int ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_DEPTH) << 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // Shared address decode. The range test is done on the full address
    // first so an address below BASE never wraps into the array.
    function automatic logic [1:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        off = addr - BASE;
        if ((addr < BASE) || (off >= MEM_BYTES)) begin
            decode = RESP_DECERR;
        end else if (addr[2:0] != 3'b000) begin
            decode = RESP_SLVERR;
        end else begin
            decode = RESP_OKAY;
        end
    endfunction

    // -----------------------------------------------------------------------
    // Storage (contents survive reset)
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // -----------------------------------------------------------------------
    // Write path
    // -----------------------------------------------------------------------
    logic              aw_held_q, aw_held_d;
    logic              w_held_q,  w_held_d;
    logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0] wstrb_q,   wstrb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;

    logic              aw_hs;
    logic              w_hs;
    logic              wr_commit;
    logic              mem_we;
    logic [1:0]        aw_resp;
    logic [ADDR_W-1:0] aw_off;
    logic [IDX_W-1:0]  aw_idx;

    always_comb begin
        aw_hs     = awvalid & ~aw_held_q;
        w_hs      = wvalid & ~w_held_q;
        // A complete AW+W pair retires only when the B slot is free, so a
        // second pair may sit in the holding registers behind a stalled B.
        wr_commit = aw_held_q & w_held_q & ~bvalid_q;
        aw_off    = awaddr_q - BASE;
        aw_idx    = aw_off[IDX_W+2:3];
        aw_resp   = decode(awaddr_q);
        mem_we    = wr_commit & (aw_resp == RESP_OKAY);

        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end

        // wr_commit implies both holds are set, so no handshake can land
        // in the same cycle and clearing them here loses nothing.
        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_resp;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-lane write. No reset on purpose: the array keeps its contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[aw_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    r_state_e          r_state_q, r_state_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    logic [1:0]        ar_resp;
    logic [ADDR_W-1:0] ar_off;
    logic [IDX_W-1:0]  ar_idx;

    // The address is decoded and the array read on the AR handshake edge;
    // only the result is kept, which holds rdata/rresp stable during R
    // back-pressure. Because the array write is non-blocking, a write to the
    // same word on the same edge is not visible here (old data returned).
    always_comb begin
        ar_off  = araddr - BASE;
        ar_idx  = ar_off[IDX_W+2:3];
        ar_resp = decode(araddr);

        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_state_d = R_DATA;
                    rresp_d   = ar_resp;
                    rdata_d   = (ar_resp == RESP_OKAY) ? mem_q[ar_idx] : '0;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all flop-driven)
    // -----------------------------------------------------------------------
    assign awready = ~aw_held_q;
    assign wready  = ~w_held_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    // Protection bits and the offset bits outside the word index carry no
    // meaning for this memory.
    logic unused_ok;
    assign unused_ok = ^{awport, arport,
                         aw_off[ADDR_W-1:IDX_W+3], aw_off[2:0],
                         ar_off[ADDR_W-1:IDX_W+3], ar_off[2:0]};

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// Bench for axi_lite_sram_slave. Inputs are driven on the falling edge and
// outputs sampled on the falling edge, half a cycle away from the active edge.
// The reference model is a byte-addressed view of the word array plus the
// address decode rules written as plain arithmetic.
// ---------------------------------------------------------------------------
module tb_axi_lite_sram_slave;

    localparam int          DEPTH     = 1024;
    localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'd8;

    logic        clk;
    logic        rst;
    logic [63:0] awaddr;
    logic [2:0]  awport;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [63:0] araddr;
    logic [2:0]  arport;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [63:0] mem_model [DEPTH];
    logic [7:0]  byte_known [DEPTH];

    axi_lite_sram_slave #(
        .C_S_AXI_ADDR_WIDTH (64),
        .C_S_AXI_DATA_WIDTH (64),
        .MEM_DEPTH          (DEPTH),
        .BASE_ADDR          (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awport  (awport),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arport  (arport),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] exp_resp(input logic [63:0] a);
        if (a < BASE || (a - BASE) >= MEM_BYTES) return 2'b11;
        if (a % 8 != 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'((a - BASE) / 8);
    endfunction

    function automatic logic [1:0] model_write(input logic [63:0] a, input logic [63:0] d,
                                               input logic [7:0] s);
        logic [1:0] r;
        int         w;
        r = exp_resp(a);
        if (r == 2'b00) begin
            w = word_of(a);
            for (int i = 0; i < 8; i++) begin
                if (s[i]) begin
                    mem_model[w][i*8 +: 8] = d[i*8 +: 8];
                    byte_known[w][i] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        if (exp_resp(a) != 2'b00) return 64'h0;
        return mem_model[word_of(a)];
    endfunction

    // true when the model can predict every bit of a read of this address
    function automatic bit model_known(input logic [63:0] a);
        if (exp_resp(a) != 2'b00) return 1'b1;
        return byte_known[word_of(a)] == 8'hFF;
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] w;
        w = 64'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return BASE + w * 8;
            6:                return BASE + MEM_BYTES - 64'd8 * 64'($urandom_range(1, 2));
            7:                return BASE + w * 8 + 64'($urandom_range(1, 7));
            8:                return BASE + MEM_BYTES + w * 8;
            default:          return BASE - 64'd8 * (w + 64'd1);
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // AW and W presented together; lat counts falling edges from the one
    // after the handshake until bvalid is seen.
    task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                             output logic [1:0] resp, output int lat);
        int t;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        t = 0;
        while (!(awready && wready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 20) begin
            miscompares++;
            $display("FAIL aw_w_handshake: waited %0d cycles, expected under 20", t);
        end
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        resp  = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    // lat counts falling edges from the one after the AR handshake until
    // rvalid is seen.
    task automatic axi_read(input logic [63:0] a, output logic [63:0] d,
                            output logic [1:0] resp, output int lat);
        int t;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 20) begin
            miscompares++;
            $display("FAIL ar_handshake: waited %0d cycles, expected under 20", t);
        end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        awaddr = '0; awport = 3'b010; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arport = 3'b101; arvalid = 1'b0; rready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b111_00_00_00) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected %b",
                     {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 9'b111_00_00_00);
        end
        vectors++;
        if (rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b111_00_00_00) begin
            miscompares++;
            $display("FAIL idle_flags: got %b expected %b",
                     {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 9'b111_00_00_00);
        end
    endtask

    task automatic test_full_write_read();
        logic [1:0]  r, er;
        logic [63:0] d;
        int          lat;
        axi_write(BASE + 64'h10, 64'hDEADBEEF_01234567, 8'hFF, r, lat);
        er = model_write(BASE + 64'h10, 64'hDEADBEEF_01234567, 8'hFF);
        vectors++;
        if (r !== er || lat !== 1) begin
            miscompares++;
            $display("FAIL full_write: bresp %b lat %0d expected bresp %b lat 1", r, lat, er);
        end
        axi_read(BASE + 64'h10, d, r, lat);
        vectors++;
        if (d !== model_read(BASE + 64'h10) || r !== 2'b00 || lat !== 0) begin
            miscompares++;
            $display("FAIL full_read: rdata %h rresp %b lat %0d expected %h 00 0",
                     d, r, lat, model_read(BASE + 64'h10));
        end
    endtask

    task automatic test_partial_w_first();
        logic [1:0]  r, er;
        logic [63:0] d;
        int          lat;
        @(negedge clk);
        wdata = 64'h11111111_22222222; wstrb = 8'h0F; wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wvalid = 1'b0;
        vectors++;
        if ({awready, wready, bvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL w_only_held: awready,wready,bvalid %b expected 100",
                     {awready, wready, bvalid});
        end
        repeat (2) @(negedge clk);
        awaddr = BASE + 64'h10; awvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        vectors++;
        if (bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_early_b: bvalid %b expected 0", bvalid);
        end
        @(negedge clk);
        er = model_write(BASE + 64'h10, 64'h11111111_22222222, 8'h0F);
        vectors++;
        if (bvalid !== 1'b1 || bresp !== er) begin
            miscompares++;
            $display("FAIL partial_b: bvalid %b bresp %b expected 1 %b", bvalid, bresp, er);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        vectors++;
        if ({awready, wready, bvalid} !== 3'b110) begin
            miscompares++;
            $display("FAIL partial_after_b: awready,wready,bvalid %b expected 110",
                     {awready, wready, bvalid});
        end
        axi_read(BASE + 64'h10, d, r, lat);
        vectors++;
        if (d !== 64'hDEADBEEF_22222222 || d !== model_read(BASE + 64'h10) || r !== 2'b00) begin
            miscompares++;
            $display("FAIL partial_read: rdata %h rresp %b expected DEADBEEF22222222 00", d, r);
        end
    endtask

    task automatic test_errors();
        logic [63:0] a, d;
        logic [7:0]  s;
        logic [1:0]  r, er;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       a = BASE + MEM_BYTES;
                1:       a = BASE - 64'd8;
                2:       a = BASE + 64'h12;
                3:       a = BASE + MEM_BYTES - 64'd8;
                default: a = BASE + 64'h10;
            endcase
            s = (i == 4) ? 8'h00 : 8'hFF;
            d = {$urandom, $urandom};
            axi_write(a, d, s, r, lat);
            er = model_write(a, d, s);
            vectors++;
            if (r !== er || lat !== 1) begin
                miscompares++;
                $display("FAIL err_write[%0d]: bresp %b lat %0d expected %b 1", i, r, lat, er);
            end
        end
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       a = BASE + 64'h13;
                1:       a = BASE + MEM_BYTES;
                2:       a = BASE - 64'd8;
                3:       a = BASE + MEM_BYTES - 64'd8;
                default: a = BASE + 64'h10;
            endcase
            axi_read(a, d, r, lat);
            vectors++;
            if (r !== exp_resp(a) || d !== model_read(a) || lat !== 0) begin
                miscompares++;
                $display("FAIL err_read[%0d]: rresp %b rdata %h lat %0d expected %b %h 0",
                         i, r, d, lat, exp_resp(a), model_read(a));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d1;
        logic [1:0]  r1, r2;
        d1 = {$urandom, $urandom};
        @(negedge clk);
        awaddr = BASE + 64'h40; wdata = d1; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
        bready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        r1 = model_write(BASE + 64'h40, d1, 8'hFF);
        araddr = BASE + 64'h10; arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bvalid !== 1'b1 || bresp !== r1) begin
                miscompares++;
                $display("FAIL b_stall[%0d]: bvalid %b bresp %b expected 1 %b", c, bvalid, bresp, r1);
            end
            if (c == 0) begin
                arvalid = 1'b0;
                vectors++;
                if (rvalid !== 1'b1 || rdata !== model_read(BASE + 64'h10) || rresp !== 2'b00) begin
                    miscompares++;
                    $display("FAIL read_during_b_stall: rvalid %b rdata %h rresp %b expected 1 %h 00",
                             rvalid, rdata, rresp, model_read(BASE + 64'h10));
                end
                rready = 1'b1;
            end else if (c == 1) begin
                rready = 1'b0;
                vectors++;
                if ({rvalid, arready, awready, wready} !== 4'b0111) begin
                    miscompares++;
                    $display("FAIL second_aw_ready: rvalid,arready,awready,wready %b expected 0111",
                             {rvalid, arready, awready, wready});
                end
                awaddr = BASE + 64'h42; wdata = {$urandom, $urandom}; wstrb = 8'hFF;
                awvalid = 1'b1; wvalid = 1'b1;
            end else if (c == 2) begin
                awvalid = 1'b0; wvalid = 1'b0;
                vectors++;
                if ({awready, wready} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL second_aw_held: awready,wready %b expected 00", {awready, wready});
                end
            end
        end
        r2 = model_write(BASE + 64'h42, wdata, 8'hFF);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        vectors++;
        if (bvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL b_gap: bvalid %b expected 0", bvalid);
        end
        @(negedge clk);
        vectors++;
        if (bvalid !== 1'b1 || bresp !== r2) begin
            miscompares++;
            $display("FAIL second_b: bvalid %b bresp %b expected 1 %b", bvalid, bresp, r2);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] d, old_d, new_d;
        logic [1:0]  r, er;
        int          lat;
        int          nsent;
        // reads with rready held high: one every two cycles
        @(negedge clk);
        araddr = BASE + 64'h40; arvalid = 1'b1; rready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (rvalid !== (c % 2 == 0) || (rvalid && rdata !== model_read(BASE + 64'h40))) begin
                miscompares++;
                $display("FAIL b2b_read[%0d]: rvalid %b rdata %h expected %b %h",
                         c, rvalid, rdata, (c % 2 == 0), model_read(BASE + 64'h40));
            end
        end
        arvalid = 1'b0;
        @(negedge clk);
        rready = 1'b0;
        // writes with bready held high: one every two cycles
        nsent = 0;
        bready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                vectors++;
                if (bvalid !== (c % 2 == 0) || (bvalid && bresp !== 2'b00)) begin
                    miscompares++;
                    $display("FAIL b2b_write[%0d]: bvalid %b bresp %b expected %b 00",
                             c, bvalid, bresp, (c % 2 == 0));
                end
            end
            if (awready && wready) begin
                if (nsent < 4) begin
                    awaddr = BASE + 64'h100 + 64'(nsent) * 8;
                    wdata  = {$urandom, $urandom};
                    wstrb  = 8'hFF;
                    awvalid = 1'b1; wvalid = 1'b1;
                    er = model_write(awaddr, wdata, wstrb);
                    nsent++;
                end else begin
                    awvalid = 1'b0; wvalid = 1'b0;
                end
            end
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            axi_read(BASE + 64'h100 + 64'(i) * 8, d, r, lat);
            vectors++;
            if (d !== model_read(BASE + 64'h100 + 64'(i) * 8) || r !== 2'b00) begin
                miscompares++;
                $display("FAIL b2b_readback[%0d]: rdata %h rresp %b expected %h 00",
                         i, d, r, model_read(BASE + 64'h100 + 64'(i) * 8));
            end
        end
        // read and write of the same word on the same edge: read sees old data
        old_d = model_read(BASE + 64'h40);
        new_d = ~old_d;
        @(negedge clk);
        awaddr = BASE + 64'h40; wdata = new_d; wstrb = 8'hFF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = BASE + 64'h40; arvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        er = model_write(BASE + 64'h40, new_d, 8'hFF);
        vectors++;
        if (rvalid !== 1'b1 || rdata !== old_d || bvalid !== 1'b1 || bresp !== er) begin
            miscompares++;
            $display("FAIL same_edge_rw: rvalid %b rdata %h bvalid %b expected 1 %h 1",
                     rvalid, rdata, bvalid, old_d);
        end
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        axi_read(BASE + 64'h40, d, r, lat);
        vectors++;
        if (d !== new_d || r !== 2'b00) begin
            miscompares++;
            $display("FAIL same_edge_after: rdata %h rresp %b expected %h 00", d, r, new_d);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, d;
        logic [7:0]  s;
        logic [1:0]  r, er;
        int          lat;
        for (int n = 0; n < 40; n++) begin
            a = rand_addr();
            if ($urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom};
                s = 8'($urandom_range(0, 255));
                axi_write(a, d, s, r, lat);
                er = model_write(a, d, s);
                vectors++;
                if (r !== er || lat !== 1) begin
                    miscompares++;
                    $display("FAIL rand_write[%0d] addr %h: bresp %b lat %0d expected %b 1",
                             n, a, r, lat, er);
                end
            end else begin
                axi_read(a, d, r, lat);
                vectors++;
                if (r !== exp_resp(a) || lat !== 0 || (model_known(a) && d !== model_read(a))) begin
                    miscompares++;
                    $display("FAIL rand_read[%0d] addr %h: rresp %b rdata %h lat %0d expected %b %h 0",
                             n, a, r, d, lat, exp_resp(a), model_read(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] d;
        logic [1:0]  r;
        int          lat;
        @(negedge clk);
        araddr = BASE + 64'h10; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        vectors++;
        if (rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_rvalid: rvalid %b expected 1", rvalid);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({rvalid, arready, rresp} !== 4'b0100 || rdata !== 64'h0) begin
            miscompares++;
            $display("FAIL async_reset: rvalid,arready,rresp %b rdata %h expected 0100 0",
                     {rvalid, arready, rresp}, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({arready, awready, wready, bvalid, rvalid} !== 5'b11100) begin
            miscompares++;
            $display("FAIL post_reset: arready,awready,wready,bvalid,rvalid %b expected 11100",
                     {arready, awready, wready, bvalid, rvalid});
        end
        axi_read(BASE + 64'h10, d, r, lat);
        vectors++;
        if (d !== model_read(BASE + 64'h10) || r !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset_read: rdata %h rresp %b expected %h 00",
                     d, r, model_read(BASE + 64'h10));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_model[i]  = '0;
            byte_known[i] = '0;
        end
        test_reset();
        test_full_write_read();
        test_partial_w_first();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
